// File: rtl/tamagotchi_pkg.sv
// Shared constants and types for the tamagotchi button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: button bit map, default timing constants for a 50 MHz clock,
// and the per-channel conditioner state enum.
package tamagotchi_pkg;

  // Button bit positions on btn_raw / btn_level / btn_press / btn_long.
  localparam int BTN_SALUD     = 0;
  localparam int BTN_ENERGIA   = 1;
  localparam int BTN_HAMBRE    = 2;
  localparam int BTN_DIVERSION = 3;
  localparam int BTN_RESET     = 4;
  localparam int BTN_TEST      = 5;
  localparam int NUM_BTN       = 6;

  // 10 ms debounce window and 5 s long-press threshold at 50 MHz.
  localparam int DEBOUNCE_10MS = 500_000;
  localparam int LONG_5S       = 250_000_000;

  typedef enum logic [2:0] {
    IDLE,
    ARMING,
    PRESSED,
    HELD,
    RELEASING
  } ch_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce filter, press and long-press pulses.
// Latency: press pulse 2 + DEBOUNCE_CYCLES edges after a steady press; long pulse LONG_CYCLES after that.
// Backpressure: none; pulses are single-cycle and the consumer must sample every cycle.
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   raw_i   - unsynchronised button pin
//   level_o - debounced level, 1 = pressed
//   press_o - one-cycle pulse when level_o rises
//   long_o  - one-cycle pulse once the press has been held LONG_CYCLES
module btn_channel
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = LONG_5S,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic long_o
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCNT_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);

  logic              pressed_raw;
  logic [1:0]        sync_q;
  logic              s2;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic              accept;
  logic              long_hit;
  ch_state_e         state_q;
  ch_state_e         ret_q;

  // Normalise polarity before synchronising so reset value 0 means "unpressed".
  assign pressed_raw = raw_i ^ ACTIVE_LOW;
  assign s2          = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pressed_raw};
    end
  end

  // accept: this edge completes a debounce window and flips the level.
  assign accept   = (s2 != level_q) && (dcnt_q == DCNT_LAST);
  // long_hit: this edge brings the hold counter to LONG_CYCLES.
  assign long_hit = level_q && (hcnt_q == HCNT_LAST);

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (s2 == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      dcnt_d  = '0;
      level_d = s2;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end

    press_d = level_d & ~level_q;

    // Hold counter saturates at LONG_CYCLES so the long pulse cannot repeat.
    hcnt_d = hcnt_q;
    if (!level_q) begin
      hcnt_d = '0;
    end else if (hcnt_q != HCNT_MAX) begin
      hcnt_d = hcnt_q + 1'b1;
    end

    long_d = long_hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ret_q   <= PRESSED;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      long_q  <= long_d;

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= PRESSED;
          end else if (s2) begin
            state_q <= ARMING;
          end
        end
        ARMING: begin
          if (accept) begin
            state_q <= PRESSED;
          end else if (!s2) begin
            state_q <= IDLE;
          end
        end
        PRESSED, HELD: begin
          if (accept) begin
            state_q <= IDLE;
          end else if (!s2) begin
            state_q <= RELEASING;
            // Remember where to return if the release turns out to be a bounce.
            ret_q   <= (long_hit || state_q == HELD) ? HELD : PRESSED;
          end else if (long_hit) begin
            state_q <= HELD;
          end
        end
        RELEASING: begin
          if (accept) begin
            state_q <= IDLE;
          end else if (s2) begin
            state_q <= long_hit ? HELD : ret_q;
          end else if (long_hit) begin
            // Level is still 1 here, so the hold threshold can expire mid-release.
            ret_q <= HELD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign long_o  = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board push-buttons into clean level, press and long-press signals.
// Latency: press 2 + DEBOUNCE_CYCLES edges after a steady press; long pulse LONG_CYCLES later.
// Backpressure: none; every output is registered and pulses last one cycle.
//
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   btn_raw   - unsynchronised button pins (bit map in tamagotchi_pkg)
//   btn_level - debounced levels, 1 = pressed
//   btn_press - one-cycle pulse per accepted press
//   btn_long  - one-cycle pulse when a press has been held LONG_CYCLES
module button_conditioner #(
  parameter int NUM_BTN         = tamagotchi_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = tamagotchi_pkg::DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = tamagotchi_pkg::LONG_5S,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_long
);

  // Channels share nothing but clock and reset.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW != 0)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .press_o(btn_press[i]),
      .long_o (btn_long[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: an active-high and an active-low instance driven in parallel.
// Latency: expected per-cycle outputs are queued when a scenario is built and popped each cycle.
// Backpressure: n/a.
module tb_button_conditioner;
  import tamagotchi_pkg::*;

  localparam int D   = 4;
  localparam int L   = 20;
  localparam int LAT = 2 + D;
  localparam int NB  = NUM_BTN;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] lng;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_raw_al;
  logic [NB-1:0] level_h, press_h, long_h;
  logic [NB-1:0] level_l, press_l, long_l;
  obs_t          obs_h, obs_l;

  always #5 clk = ~clk;

  // The active-low instance sees the inverted pins, so it must behave identically.
  assign btn_raw_al = ~btn_raw;
  assign obs_h = {level_h, press_h, long_h};
  assign obs_l = {level_l, press_l, long_l};

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(0)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(level_h), .btn_press(press_h), .btn_long(long_h)
  );

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_al),
    .btn_level(level_l), .btn_press(press_l), .btn_long(long_l)
  );

  int            checks = 0;
  int            errors = 0;
  obs_t          exp_q[$];
  logic [NB-1:0] stim_q[$];
  int            ts[NB];   // cycle a steady press starts (-1: never)
  int            tr[NB];   // cycle the press is released
  int            rc;       // cycle rst_n drops for two cycles (-1: never)

  task automatic check_val(input string tag, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: level/press/long got %h/%h/%h want %h/%h/%h",
               tag, act.level, act.press, act.lng, exp.level, exp.press, exp.lng);
    end
  endtask

  // Expected {level, press, long} of one channel after edge n, from the timing rules alone.
  function automatic logic [2:0] chan_exp(input int n, input int ch);
    int  s;
    logic lv, pr, lg;
    if (ts[ch] < 0) return 3'b000;
    s = ts[ch];
    if (rc >= 0 && n > rc) begin
      if (n <= rc + 2) return 3'b000;
      s = rc + 2;  // still held after reset release: a fresh press
    end
    lv = (n >= s + LAT) && (n < tr[ch] + LAT);
    pr = (n == s + LAT);
    lg = (n == s + LAT + L) && (n <= tr[ch] + LAT);
    return {lv, pr, lg};
  endfunction

  task automatic clear_scenario();
    for (int ch = 0; ch < NB; ch++) begin
      ts[ch] = -1;
      tr[ch] = 1000;
    end
    rc = -1;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic run_scenario(input string name, input int n_cyc);
    obs_t       e;
    logic [2:0] b;
    for (int n = 1; n <= n_cyc; n++) begin
      e = '0;
      for (int ch = 0; ch < NB; ch++) begin
        b = chan_exp(n, ch);
        e.level[ch] = b[2];
        e.press[ch] = b[1];
        e.lng[ch]   = b[0];
      end
      exp_q.push_back(e);
    end

    rst_n   = 1'b0;
    btn_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val($sformatf("%s:reset_hi", name), obs_h, '0);
    check_val($sformatf("%s:reset_lo", name), obs_l, '0);
    rst_n = 1'b1;

    for (int c = 0; c < n_cyc; c++) begin
      btn_raw = stim_q[c];
      if (c == rc) begin
        rst_n = 1'b0;
        #1;
        check_val($sformatf("%s:async_rst_hi", name), obs_h, '0);
        check_val($sformatf("%s:async_rst_lo", name), obs_l, '0);
      end
      if (rc >= 0 && c == rc + 2) rst_n = 1'b1;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_val($sformatf("%s:hi:n%0d", name, c + 1), obs_h, e);
      check_val($sformatf("%s:lo:n%0d", name, c + 1), obs_l, e);
    end
  endtask

  initial begin
    // Steady press on salud.
    clear_scenario();
    ts[BTN_SALUD] = 0;
    for (int c = 0; c < 30; c++) stim_q.push_back(6'b000001);
    run_scenario("steady0", 30);

    // Three-cycle glitch on hambre: must be filtered out entirely.
    clear_scenario();
    for (int c = 0; c < 15; c++) stim_q.push_back(c < 3 ? 6'b000100 : 6'b000000);
    run_scenario("glitch2", 15);

    // Hold test for 40 cycles: one press, one long pulse, release 6 cycles later.
    clear_scenario();
    ts[BTN_TEST] = 0;
    tr[BTN_TEST] = 40;
    for (int c = 0; c < 50; c++) stim_q.push_back(c < 40 ? 6'b100000 : 6'b000000);
    run_scenario("hold5", 50);

    // Energia bounces every cycle for 10 cycles, then settles high.
    clear_scenario();
    ts[BTN_ENERGIA] = 10;
    for (int c = 0; c < 40; c++)
      stim_q.push_back((c >= 10 || (c % 2) == 0) ? 6'b000010 : 6'b000000);
    run_scenario("bounce1", 40);

    // Simultaneous presses on salud and diversion.
    clear_scenario();
    ts[BTN_SALUD]     = 0;
    ts[BTN_DIVERSION] = 0;
    for (int c = 0; c < 30; c++) stim_q.push_back(6'b001001);
    run_scenario("simul03", 30);

    // Reset pulled mid-hold on the reset button.
    clear_scenario();
    ts[BTN_RESET] = 0;
    rc = 10;
    for (int c = 0; c < 30; c++) stim_q.push_back(6'b010000);
    run_scenario("rsthold4", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
